// File: rtl/multicyc_mcu.sv
// multicyc_mcu: main control FSM sequencing the multi-cycle MIPS datapath
module multicyc_mcu (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       eq,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_we,
    output logic       ir_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_src,
    output logic [3:0] state_dbg,
    output logic       instr_done,
    output logic       illegal_op
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    state_t state, next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    assign state_dbg = state;

    always_comb begin
        next       = FETCH;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        aluop      = 2'b00;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_en     = mem_ready;
                next      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // branch target is precomputed here while the opcode is decoded
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECUTE;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEXEC;
                    OP_J:         next = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                        next       = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                next      = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                next = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
                next       = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                aluop     = 2'b10;
                next      = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                aluop      = 2'b01;
                pc_src     = 2'b01;
                pc_en      = eq;
                instr_done = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                next      = ADDIWB;
            end
            ADDIWB: begin
                reg_we     = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: next = FETCH;
        endcase
        // no write or pulse may escape while reset is held
        if (reset) begin
            pc_en      = 1'b0;
            ir_we      = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicyc_mcu.sv
// tb_multicyc_mcu: scoreboard bench driving instruction sequences into the control FSM
module tb_multicyc_mcu;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       eq;
    logic       mem_ready;
    logic       pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a;
    logic [1:0] alu_src_b, aluop, pc_src;
    logic [3:0] state_dbg;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;
    logic [19:0] q[$];

    multicyc_mcu dut (
        .clk(clk), .reset(reset), .opcode(opcode), .eq(eq), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_we(mem_we), .ir_we(ir_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_we(reg_we),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
        .pc_src(pc_src), .state_dbg(state_dbg), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic legal(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // expected outputs for one cycle spent in state s, straight from the state table
    function automatic logic [19:0] exp_vec(int s, logic [5:0] op, logic e, logic mr);
        logic pe = 0, io = 0, mw = 0, iw = 0, rd = 0, m2r = 0, rw = 0, a = 0, dn = 0, il = 0;
        logic [1:0] b = 0, ao = 0, ps = 0;
        case (s)
            0:  begin b = 2'b01; iw = mr; pe = mr; end
            1:  begin b = 2'b11; il = !legal(op); dn = !legal(op); end
            2:  begin a = 1; b = 2'b10; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin io = 1; mw = 1; dn = mr; end
            6:  begin a = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; dn = 1; end
            8:  begin a = 1; ao = 2'b01; ps = 2'b01; pe = e; dn = 1; end
            9:  begin a = 1; b = 2'b10; end
            10: begin rw = 1; dn = 1; end
            11: begin ps = 2'b10; pe = 1; dn = 1; end
            default: ;
        endcase
        return {4'(s), pe, io, mw, iw, rd, m2r, rw, a, b, ao, ps, dn, il};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(int s, logic mr, logic e);
        mem_ready = mr;
        eq = e;
        q.push_back(exp_vec(s, opcode, e, mr));
        @(posedge clk);
        #1;
    endtask

    // fw: fetch wait cycles, mw: memory wait cycles, be: eq seen in BRANCH
    task automatic run_instr(logic [5:0] op, int fw, int mw, logic be);
        opcode = op;
        repeat (fw) step(0, 0, rb());
        step(0, 1, rb());
        step(1, rb(), rb());
        case (op)
            OP_LW: begin
                step(2, rb(), rb());
                repeat (mw) step(3, 0, rb());
                step(3, 1, rb());
                step(4, rb(), rb());
            end
            OP_SW: begin
                step(2, rb(), rb());
                repeat (mw) step(5, 0, rb());
                step(5, 1, rb());
            end
            OP_R: begin
                step(6, rb(), rb());
                step(7, rb(), rb());
            end
            OP_BEQ: step(8, rb(), be);
            OP_ADDI: begin
                step(9, rb(), rb());
                step(10, rb(), rb());
            end
            OP_J: step(11, rb(), rb());
            default: ;
        endcase
    endtask

    initial begin
        logic [19:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                act_v = {state_dbg, pc_en, iord, mem_we, ir_we, reg_dst, mem_to_reg, reg_we,
                         alu_src_a, alu_src_b, aluop, pc_src, instr_done, illegal_op};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL seq act=%h exp=%h state=%0d", act_v, exp_v, state_dbg);
                end
                checks++;
                if (int'(reg_we) + int'(mem_we) + int'(pc_en && state_dbg != 0) > 1) begin
                    errors++;
                    $display("FAIL excl act=%b%b%b exp=at_most_one", reg_we, mem_we, pc_en);
                end
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        reset = 1; opcode = 0; eq = 0; mem_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state_dbg, 0);
        chk("reset_en", {pc_en, ir_we, mem_we, reg_we, instr_done, illegal_op}, 0);
        chk("reset_sel", {alu_src_b, aluop, pc_src, iord, alu_src_a}, 8'b01000000);
        reset = 0;
        run_instr(OP_LW, 0, 0, 0);
        run_instr(OP_SW, 0, 3, 0);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_R, 0, 0, 0);
        run_instr(OP_ADDI, 0, 0, 0);
        run_instr(OP_J, 0, 0, 0);
        run_instr(6'h3f, 0, 0, 0);
        opcode = OP_R;
        step(0, 1, 0);
        step(1, 1, 0);
        chk("pre_rst_exec", state_dbg, 6);
        mem_ready = 1;
        #2 reset = 1;
        #1;
        chk("async_rst_state", state_dbg, 0);
        chk("async_rst_en", {pc_en, ir_we, mem_we, reg_we, instr_done}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_state", state_dbg, 0);
            chk("rst_hold_en", {pc_en, ir_we, mem_we, reg_we, instr_done}, 0);
        end
        @(posedge clk);
        #1 reset = 0;
        run_instr(OP_ADDI, 1, 0, 0);
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end
        @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
